// File: rtl/retire_pkg.sv
// retire_pkg: shared types and constants for the commit-trace stage.
//   retire_rec_t  - one retired-instruction record as seen by the trace consumer
//   shadow_slot_t - pc/instruction tag carried alongside an EX/MEM/WB pipeline slot
//   NOP_INST      - canonical addi x0,x0,0 that the CPU injects as a bubble
//   HALT_INST     - all-zero word that marks end-of-program when it reaches WB
package retire_pkg;

  // Record/slot width. The top-level XLEN parameter must match this value.
  localparam int REC_XLEN = 32;

  localparam logic [31:0] NOP_INST  = 32'h0000_0013;
  localparam logic [31:0] HALT_INST = 32'h0000_0000;

  typedef struct packed {
    logic [REC_XLEN-1:0] pc;
    logic [31:0]         inst;
    logic                we;
    logic [4:0]          rd;
    logic [REC_XLEN-1:0] wdata;
  } retire_rec_t;

  typedef struct packed {
    logic [REC_XLEN-1:0] pc;
    logic [31:0]         inst;
    logic                valid;
  } shadow_slot_t;

  function automatic logic is_halt_inst(input logic [31:0] inst);
    return inst == HALT_INST;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: synchronous FIFO of retire records.
//   clk_i, rst_i : clock, synchronous active-high reset (pointers only)
//   push, wr_rec : write request and record; ignored when full unless a pop
//                  happens in the same cycle
//   full, empty  : occupancy flags
//   pop          : remove head; ignored when empty
//   rd_rec       : current head record (meaningful only when !empty)
module trace_fifo
  import retire_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push,
  input  retire_rec_t wr_rec,
  output logic        full,
  input  logic        pop,
  output logic        empty,
  output retire_rec_t rd_rec
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  retire_rec_t mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  // A simultaneous pop frees the slot, so push-while-full is accepted then.
  assign do_push = push & (~full | do_pop);
  assign rd_rec  = mem[rptr[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_ONE;
      if (do_pop)  rptr <= rptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr[AW-1:0]] <= wr_rec;
  end

endmodule

// File: rtl/retire_tracker.sv
// retire_tracker: commit-trace stage for the 5-stage RISC-V CPU.
// Shadows EX/MEM/WB with pc/instruction tags and emits one record per
// architecturally retired instruction into a trace FIFO.
//   clk_i, rst_i              : clock, synchronous active-high reset
//   id_valid_i/id_pc_i/id_inst_i : ID-stage instruction and its validity
//   hazard_stall_i, flush_i   : CPU stall (bubble into EX) and squash of ID
//   wb_we_i/wb_rd_i/wb_data_i : register-file write of the WB instruction
//   trace_valid_o/trace_ready_i : FIFO head handshake
//   trace_pc_o .. trace_wdata_o : FIFO head record
//   halt_o     : sticky, zero instruction reached WB
//   overflow_o : sticky, a record was dropped on a full FIFO
//   retired_o  : retired-instruction count (wraps)
// XLEN must equal retire_pkg::REC_XLEN.
module retire_tracker
  import retire_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            id_valid_i,
  input  logic [XLEN-1:0] id_pc_i,
  input  logic [31:0]     id_inst_i,
  input  logic            hazard_stall_i,
  input  logic            flush_i,
  input  logic            wb_we_i,
  input  logic [4:0]      wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  output logic            trace_valid_o,
  input  logic            trace_ready_i,
  output logic [XLEN-1:0] trace_pc_o,
  output logic [31:0]     trace_inst_o,
  output logic            trace_we_o,
  output logic [4:0]      trace_rd_o,
  output logic [XLEN-1:0] trace_wdata_o,
  output logic            halt_o,
  output logic            overflow_o,
  output logic [31:0]     retired_o
);

  shadow_slot_t ex_p0;
  shadow_slot_t mem_p1;
  shadow_slot_t wb_p2;

  logic        retire_en;
  logic        halt_hit;
  logic        push;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;
  retire_rec_t push_rec;
  retire_rec_t head_rec;

  // EX/MEM/WB shadow: tags advance unconditionally; reset clears only the
  // valid bits (the later non-blocking assignment wins).
  always_ff @(posedge clk_i) begin
    ex_p0  <= '{pc: id_pc_i, inst: id_inst_i,
                valid: id_valid_i & ~hazard_stall_i & ~flush_i};
    mem_p1 <= ex_p0;
    wb_p2  <= mem_p1;
    if (rst_i) begin
      ex_p0.valid  <= 1'b0;
      mem_p1.valid <= 1'b0;
      wb_p2.valid  <= 1'b0;
    end
  end

  // WB retire: once halted, every later WB slot is ignored.
  assign retire_en = wb_p2.valid & ~halt_o;
  assign halt_hit  = retire_en &  is_halt_inst(wb_p2.inst);
  assign push      = retire_en & ~is_halt_inst(wb_p2.inst);
  assign pop       = ~fifo_empty & trace_ready_i;

  // Writes to x0 are not architectural, so they are reported as we=0.
  assign push_rec = '{pc: wb_p2.pc, inst: wb_p2.inst,
                      we: wb_we_i & (wb_rd_i != 5'd0),
                      rd: wb_rd_i, wdata: wb_data_i};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      halt_o     <= 1'b0;
      overflow_o <= 1'b0;
      retired_o  <= '0;
    end else begin
      if (halt_hit) halt_o <= 1'b1;
      // The count tracks retirement even when the record itself is dropped.
      if (push) retired_o <= retired_o + 32'd1;
      if (push & fifo_full & ~pop) overflow_o <= 1'b1;
    end
  end

  trace_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push   (push),
    .wr_rec (push_rec),
    .full   (fifo_full),
    .pop    (pop),
    .empty  (fifo_empty),
    .rd_rec (head_rec)
  );

  assign trace_valid_o = ~fifo_empty;
  assign trace_pc_o    = head_rec.pc;
  assign trace_inst_o  = head_rec.inst;
  assign trace_we_o    = head_rec.we;
  assign trace_rd_o    = head_rec.rd;
  assign trace_wdata_o = head_rec.wdata;

endmodule

// File: tb/tb_retire_tracker.sv
module tb_retire_tracker;
  import retire_pkg::*;

  localparam int XLEN  = 32;
  localparam int DEPTH = 8;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            id_valid_i;
  logic [XLEN-1:0] id_pc_i;
  logic [31:0]     id_inst_i;
  logic            hazard_stall_i;
  logic            flush_i;
  logic            wb_we_i;
  logic [4:0]      wb_rd_i;
  logic [XLEN-1:0] wb_data_i;
  logic            trace_valid_o;
  logic            trace_ready_i;
  logic [XLEN-1:0] trace_pc_o;
  logic [31:0]     trace_inst_o;
  logic            trace_we_o;
  logic [4:0]      trace_rd_o;
  logic [XLEN-1:0] trace_wdata_o;
  logic            halt_o;
  logic            overflow_o;
  logic [31:0]     retired_o;

  retire_tracker #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .id_valid_i     (id_valid_i),
    .id_pc_i        (id_pc_i),
    .id_inst_i      (id_inst_i),
    .hazard_stall_i (hazard_stall_i),
    .flush_i        (flush_i),
    .wb_we_i        (wb_we_i),
    .wb_rd_i        (wb_rd_i),
    .wb_data_i      (wb_data_i),
    .trace_valid_o  (trace_valid_o),
    .trace_ready_i  (trace_ready_i),
    .trace_pc_o     (trace_pc_o),
    .trace_inst_o   (trace_inst_o),
    .trace_we_o     (trace_we_o),
    .trace_rd_o     (trace_rd_o),
    .trace_wdata_o  (trace_wdata_o),
    .halt_o         (halt_o),
    .overflow_o     (overflow_o),
    .retired_o      (retired_o)
  );

  always #5 clk_i = ~clk_i;

  // Minimal CPU writeback side: an accepted addi xN,x0,imm writes imm to xN
  // three edges later; bubbles write nothing.
  logic [4:0]  cpu_rd0, cpu_rd1, cpu_rd2;
  logic [31:0] cpu_d0, cpu_d1, cpu_d2;
  logic        acc;
  assign acc = id_valid_i & ~hazard_stall_i & ~flush_i;
  always @(posedge clk_i) begin
    cpu_rd0 <= acc ? id_inst_i[11:7] : 5'd0;
    cpu_d0  <= acc ? {{20{id_inst_i[31]}}, id_inst_i[31:20]} : 32'd0;
    cpu_rd1 <= cpu_rd0;
    cpu_d1  <= cpu_d0;
    cpu_rd2 <= cpu_rd1;
    cpu_d2  <= cpu_d1;
  end
  assign wb_we_i   = 1'b1;
  assign wb_rd_i   = cpu_rd2;
  assign wb_data_i = cpu_d2;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [11:0] imm);
    return {imm, 5'd0, 3'b000, rd, 7'h13};
  endfunction

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic st, input logic fl);
    @(negedge clk_i);
    id_valid_i     = v;
    id_pc_i        = pc;
    id_inst_i      = inst;
    hazard_stall_i = st;
    flush_i        = fl;
  endtask

  task automatic idle();
    drive(1'b0, 32'd0, NOP_INST, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        stall;
    logic        flush;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] einst;
    logic [4:0]  erd;
    logic [31:0] ewd;
    logic [31:0] eret;
  } vec_t;

  vec_t tbl[10];
  int   seen;

  initial begin
    // Row i is applied before edge i+1; expectations hold just after that edge.
    tbl[0] = '{1'b1, 32'h10008, addi(1, 5), 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 32'd0, 32'd0};
    tbl[1] = '{1'b1, 32'h1000C, addi(2, 6), 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 32'd0, 32'd0};
    tbl[2] = '{1'b1, 32'h10010, addi(3, 7), 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 32'd0, 32'd0};
    tbl[3] = '{1'b1, 32'h10010, addi(3, 7), 1'b0, 1'b0, 1'b1, 32'h10008, 32'h00500093, 5'd1, 32'd5, 32'd1};
    tbl[4] = '{1'b1, 32'h10014, addi(4, 8), 1'b0, 1'b1, 1'b1, 32'h1000C, 32'h00600113, 5'd2, 32'd6, 32'd2};
    tbl[5] = '{1'b1, 32'h10018, addi(5, 9), 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 32'd0, 32'd2};
    tbl[6] = '{1'b0, 32'h0, NOP_INST, 1'b0, 1'b0, 1'b1, 32'h10010, 32'h00700193, 5'd3, 32'd7, 32'd3};
    tbl[7] = '{1'b0, 32'h0, NOP_INST, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 32'd0, 32'd3};
    tbl[8] = '{1'b0, 32'h0, NOP_INST, 1'b0, 1'b0, 1'b1, 32'h10018, 32'h00900293, 5'd5, 32'd9, 32'd4};
    tbl[9] = '{1'b0, 32'h0, NOP_INST, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 32'd0, 32'd4};

    rst_i = 1'b1;
    trace_ready_i = 1'b1;
    id_valid_i = 1'b0; id_pc_i = '0; id_inst_i = NOP_INST;
    hazard_stall_i = 1'b0; flush_i = 1'b0;
    step();
    step();
    chk("reset.valid",    {31'd0, trace_valid_o}, 32'd0);
    chk("reset.halt",     {31'd0, halt_o},        32'd0);
    chk("reset.overflow", {31'd0, overflow_o},    32'd0);
    chk("reset.retired",  retired_o,              32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Back-to-back, stall and flush.
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].v, tbl[i].pc, tbl[i].inst, tbl[i].stall, tbl[i].flush);
      step();
      chk($sformatf("vec%0d.valid", i), {31'd0, trace_valid_o}, {31'd0, tbl[i].ev});
      chk($sformatf("vec%0d.retired", i), retired_o, tbl[i].eret);
      if (tbl[i].ev) begin
        chk($sformatf("vec%0d.pc", i),    trace_pc_o,    tbl[i].epc);
        chk($sformatf("vec%0d.inst", i),  trace_inst_o,  tbl[i].einst);
        chk($sformatf("vec%0d.we", i),    {31'd0, trace_we_o}, 32'd1);
        chk($sformatf("vec%0d.rd", i),    {27'd0, trace_rd_o}, {27'd0, tbl[i].erd});
        chk($sformatf("vec%0d.wdata", i), trace_wdata_o, tbl[i].ewd);
      end
    end
    chk("vec.overflow", {31'd0, overflow_o}, 32'd0);

    // Full FIFO: ready low, 10 instructions, two dropped.
    @(negedge clk_i);
    trace_ready_i = 1'b0;
    for (int e = 1; e <= 14; e++) begin
      if (e <= 10) drive(1'b1, 32'h20000 + 32'(4 * (e - 1)), addi(5'(e), 12'(100 + e - 1)), 1'b0, 1'b0);
      else idle();
      step();
      if (e == 11) chk("full.ovf_at_8", {31'd0, overflow_o}, 32'd0);
      if (e == 12) begin
        chk("full.ovf_at_9", {31'd0, overflow_o}, 32'd1);
        chk("full.head_pc_e12", trace_pc_o, 32'h20000);
      end
    end
    chk("full.retired", retired_o, 32'd14);
    chk("full.valid", {31'd0, trace_valid_o}, 32'd1);
    chk("full.head_stable", trace_pc_o, 32'h20000);
    @(negedge clk_i);
    trace_ready_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("drain%0d.valid", k), {31'd0, trace_valid_o}, 32'd1);
      chk($sformatf("drain%0d.pc", k),    trace_pc_o, 32'h20000 + 32'(4 * k));
      chk($sformatf("drain%0d.rd", k),    {27'd0, trace_rd_o}, 32'(k + 1));
      chk($sformatf("drain%0d.wdata", k), trace_wdata_o, 32'(100 + k));
      step();
    end
    chk("drain.empty", {31'd0, trace_valid_o}, 32'd0);
    chk("drain.ovf_sticky", {31'd0, overflow_o}, 32'd1);

    // Reset with 4 queued records and 2 in flight.
    @(negedge clk_i);
    trace_ready_i = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      if (e <= 6) drive(1'b1, 32'h40000 + 32'(4 * (e - 1)), addi(5'(e), 12'(e)), 1'b0, 1'b0);
      else idle();
      step();
    end
    chk("prerst.retired", retired_o, 32'd18);
    chk("prerst.head", trace_pc_o, 32'h40000);
    idle();
    rst_i = 1'b1;
    step();
    chk("midrst.valid",    {31'd0, trace_valid_o}, 32'd0);
    chk("midrst.halt",     {31'd0, halt_o},        32'd0);
    chk("midrst.overflow", {31'd0, overflow_o},    32'd0);
    chk("midrst.retired",  retired_o,              32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int e = 0; e < 5; e++) begin
      idle();
      step();
    end
    chk("postrst.valid",   {31'd0, trace_valid_o}, 32'd0);
    chk("postrst.retired", retired_o,              32'd0);

    // Halt: zero instruction followed by valid instructions.
    @(negedge clk_i);
    trace_ready_i = 1'b1;
    seen = 0;
    for (int e = 1; e <= 10; e++) begin
      case (e)
        1: drive(1'b1, 32'h30000, addi(1, 5), 1'b0, 1'b0);
        2: drive(1'b1, 32'h30004, HALT_INST,  1'b0, 1'b0);
        3: drive(1'b1, 32'h30008, addi(2, 6), 1'b0, 1'b0);
        4: drive(1'b1, 32'h3000C, addi(3, 7), 1'b0, 1'b0);
        default: idle();
      endcase
      step();
      if (trace_valid_o) seen++;
      if (e == 4) begin
        chk("halt.pre_flag", {31'd0, halt_o}, 32'd0);
        chk("halt.pre_pc", trace_pc_o, 32'h30000);
      end
      if (e == 5) chk("halt.flag_set", {31'd0, halt_o}, 32'd1);
    end
    chk("halt.records", 32'(seen), 32'd1);
    chk("halt.retired", retired_o, 32'd1);
    chk("halt.sticky",  {31'd0, halt_o}, 32'd1);
    chk("halt.valid",   {31'd0, trace_valid_o}, 32'd0);
    idle();
    rst_i = 1'b1;
    step();
    chk("halt.cleared", {31'd0, halt_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
